mfp_div_seq: RTL and testbench

Sequential fixed-point divider for the MFixPoint toolbox, the inverse of the `MFP_Multi` multiplier. It computes a quotient of two fixed-point operands with a restoring shift-subtract loop, one quotient bit per clock. It shares the toolbox's conventions for signedness, symmetric saturation and floor/round selection. It sits in datapaths that need normalisation or ratio terms, such as gradient-orientation and contrast ratios, where a combinational divider is too large.

---
 rtl/mfp_pkg.sv | 12 +
 rtl/mfp_div_step.sv | 21 ++
 rtl/mfp_div_seq.sv | 135 +++++++++++++
 tb/tb_mfp_div_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mfp_pkg.sv
// mfp_pkg: shared constants and helpers for the MFixPoint sequential toolbox blocks
package mfp_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [63:0] mfp_max_pos(input int width, input bit is_unsigned);
        return is_unsigned ? (64'd1 << width) - 64'd1 : (64'd1 << (width - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/mfp_div_step.sv
// mfp_div_step: one combinational restoring-division step (shift in a bit, conditionally subtract)
module mfp_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] sh;
    logic [W:0] diff;

    // remainder < divisor on entry, so a non-borrow difference always fits in W bits
    assign sh    = {rem_i, bit_i};
    assign diff  = sh - {1'b0, div_i};
    assign q_o   = !diff[W];
    assign rem_o = q_o ? diff[W-1:0] : sh[W-1:0];

endmodule

// File: rtl/mfp_div_seq.sv
// mfp_div_seq: sequential fixed-point divider, one quotient bit per clock,
// with symmetric saturation and optional round-half-away-from-zero.
import mfp_pkg::*;

module mfp_div_seq #(
    parameter int In1W       = 16,
    parameter int In2W       = In1W,
    parameter int OutW       = In1W,
    parameter int FracW      = 0,
    parameter bit isFloor    = 1,
    parameter bit Saturate   = 1,
    parameter bit isUnsigned = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [In1W-1:0] in_dividend,
    input  logic [In2W-1:0] in_divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OutW-1:0] out_data,
    output logic            out_div0
);

    localparam int NW   = In1W + FracW;
    localparam int ITER = NW + (isFloor ? 0 : 1);
    localparam int CW   = $clog2(ITER + 1);
    localparam int QW   = NW + 1;
    localparam logic [63:0]     MAX_POS = mfp_max_pos(OutW, isUnsigned);
    localparam logic [OutW-1:0] MAX_O   = OutW'(MAX_POS);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   dvd_q, dvd_d;
    logic [In2W-1:0] dvs_q, dvs_d, rem_q, rem_d, rem_nx;
    logic [ITER-1:0] quot_q, quot_d, quot_nx;
    logic            sign_q, sign_d, div0_q, div0_d, qbit;
    logic [OutW-1:0] out_data_q, out_data_d;

    logic            dvd_neg, dvs_neg, ovf;
    logic [In1W-1:0] dvd_mag;
    logic [In2W-1:0] dvs_mag;
    logic [QW-1:0]   q_mag;
    logic [OutW-1:0] q_trunc, fin;

    mfp_div_step #(.W(In2W)) u_step (
        .rem_i (rem_q),
        .div_i (dvs_q),
        .bit_i (dvd_q[NW-1]),
        .rem_o (rem_nx),
        .q_o   (qbit)
    );

    assign dvd_neg = !isUnsigned && in_dividend[In1W-1];
    assign dvs_neg = !isUnsigned && in_divisor[In2W-1];
    assign dvd_mag = dvd_neg ? -in_dividend : in_dividend;
    assign dvs_mag = dvs_neg ? -in_divisor : in_divisor;

    // finalize works on the quotient including this cycle's bit so DONE follows the last step directly
    assign quot_nx = {quot_q[ITER-2:0], qbit};
    assign q_mag   = isFloor ? QW'(quot_nx) : QW'(quot_nx >> 1) + QW'(quot_nx[0]);
    assign ovf     = 64'(q_mag) > MAX_POS;
    assign q_trunc = OutW'(q_mag);
    assign fin     = (Saturate && ovf) ? (sign_q ? -MAX_O : MAX_O) : (sign_q ? -q_trunc : q_trunc);

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_div0  = div0_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        sign_d     = sign_q;
        div0_d     = div0_q;
        out_data_d = out_data_q;
        if (state_q == IDLE && in_valid) begin
            if (in_divisor == '0) begin
                state_d    = DONE;
                div0_d     = 1'b1;
                out_data_d = dvd_neg ? -MAX_O : MAX_O;
            end else begin
                state_d = CALC;
                dvd_d   = NW'(dvd_mag) << FracW;
                dvs_d   = dvs_mag;
                sign_d  = dvd_neg ^ dvs_neg;
                rem_d   = '0;
                quot_d  = '0;
                cnt_d   = CW'(ITER);
            end
        end else if (state_q == CALC) begin
            rem_d  = rem_nx;
            quot_d = quot_nx;
            dvd_d  = dvd_q << 1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d    = DONE;
                div0_d     = 1'b0;
                out_data_d = fin;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            sign_q     <= 1'b0;
            div0_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            sign_q     <= sign_d;
            div0_q     <= div0_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mfp_div_seq.sv
// tb_mfp_div_seq: table-driven bench over five divider configurations with a result scoreboard
module tb_mfp_div_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       ir [5];
    logic       ov [5];
    logic       dz [5];
    logic [7:0] od [5];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: default, 1: round, 2: wrap, 3: unsigned, 4: FracW=4
    mfp_div_seq #(.In1W(8)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_dividend(a), .in_divisor(b),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_div0(dz[0]));
    mfp_div_seq #(.In1W(8), .isFloor(1'b0)) u_rnd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_dividend(a), .in_divisor(b),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_div0(dz[1]));
    mfp_div_seq #(.In1W(8), .Saturate(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_dividend(a), .in_divisor(b),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_div0(dz[2]));
    mfp_div_seq #(.In1W(8), .isUnsigned(1'b1)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_dividend(a), .in_divisor(b),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_div0(dz[3]));
    mfp_div_seq #(.In1W(8), .FracW(4)) u_frac (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .in_dividend(a), .in_divisor(b),
        .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .out_div0(dz[4]));

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       z;
        int         lat;
    } vec_t;

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       z;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ir[0] && ir[1] && ir[2] && ir[3] && ir[4]) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk("in_ready_pre", 32'(ir[v.sel]), 32'd1);
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        sb.push_back('{v.sel, v.d, v.z, v.lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
        // latency counts the accept edge as clock 1
        lat = 1;
        while (!ov[v.sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk($sformatf("lat_%0d_%0h_%0h", e.sel, v.a, v.b), 32'(lat), 32'(e.lat));
        chk($sformatf("data_%0d_%0h_%0h", e.sel, v.a, v.b), 32'(od[e.sel]), 32'(e.d));
        chk($sformatf("div0_%0d_%0h_%0h", e.sel, v.a, v.b), 32'(dz[e.sel]), 32'(e.z));
        @(posedge clk); #1;
        chk("ready_after_hs", 32'(ir[e.sel]), 32'd1);
        chk("valid_after_hs", 32'(ov[e.sel]), 32'd0);
        wait_idle();
    endtask

    initial begin
        vecs.push_back('{0, 8'd100, 8'd7,   8'd14,  1'b0, 9});
        vecs.push_back('{0, 8'h9C,  8'd7,   8'hF2,  1'b0, 9});
        vecs.push_back('{1, 8'd100, 8'd8,   8'd13,  1'b0, 10});
        vecs.push_back('{1, 8'h9C,  8'd8,   8'hF3,  1'b0, 10});
        vecs.push_back('{1, 8'd99,  8'd8,   8'd12,  1'b0, 10});
        vecs.push_back('{0, 8'h80,  8'hFF,  8'h7F,  1'b0, 9});
        vecs.push_back('{2, 8'h80,  8'hFF,  8'h80,  1'b0, 9});
        vecs.push_back('{0, 8'd5,   8'd0,   8'h7F,  1'b1, 1});
        vecs.push_back('{0, 8'hFB,  8'd0,   8'h81,  1'b1, 1});
        vecs.push_back('{0, 8'd0,   8'd0,   8'h7F,  1'b1, 1});
        vecs.push_back('{3, 8'd200, 8'd0,   8'hFF,  1'b1, 1});
        vecs.push_back('{3, 8'd200, 8'd7,   8'd28,  1'b0, 9});
        vecs.push_back('{4, 8'd1,   8'd3,   8'd5,   1'b0, 13});
        vecs.push_back('{4, 8'd15,  8'd2,   8'h78,  1'b0, 13});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir[0]), 32'd0);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_data", 32'(od[0]), 32'd0);
        chk("rst_out_div0", 32'(dz[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(ir[0]), 32'd1);

        foreach (vecs[i]) run(vecs[i]);

        // backpressure: result held, pulsed in_valid ignored
        out_ready = 1'b0;
        @(negedge clk);
        a = 8'd100;
        b = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 40 && !ov[0]; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", 32'(ov[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                @(negedge clk);
                a = 8'd3;
                b = 8'd1;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_data", 32'(od[0]), 32'd14);
            chk("bp_hold_valid", 32'(ov[0]), 32'd1);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(ov[0]), 32'd0);
        chk("bp_release_ready", 32'(ir[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_pulse_ignored", 32'(ov[0]), 32'd0);
        wait_idle();

        // reset mid-CALC discards the operation
        @(negedge clk);
        a = 8'd100;
        b = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        chk("midrst_ready", 32'(ir[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(ir[0]), 32'd1);
        chk("midrst_release_ready_frac", 32'(ir[4]), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(ov[0]), 32'd0);

        run('{0, 8'd50, 8'd5, 8'd10, 1'b0, 9});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
